// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit request -> LO/HI 16-bit async SRAM beats; rsp_valid 2*WAIT_CYCLES+1 cycles after accept; req_ready low while busy.
// Optional SRAM_CTRL_BEAT_SKIP_EN: write beats whose byte-enable pair is 00 are skipped entirely.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] New_adr,
  inout  wire  [15:0]       MemData,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              CE,
  output logic              UB,
  output logic              LB
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

`ifdef SRAM_CTRL_BEAT_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [15:0]       dout;
    logic              drive;
    logic              mem_write;
    logic              mem_read;
    logic              ce;
    logic              ub;
    logic              lb;
  } bus_t;

  function automatic bus_t beat_bus(input logic hi, input logic we, input logic [ADDR_W-2:0] idx,
                                    input logic [31:0] wdata, input logic [3:0] be);
    bus_t b;
    b.adr       = {idx, hi};
    b.dout      = hi ? wdata[31:16] : wdata[15:0];
    b.drive     = we;
    b.mem_write = we;
    b.mem_read  = ~we;
    b.ce        = 1'b0;
    // Reads always fetch both bytes; writes map the beat's enable pair onto the lanes.
    b.lb        = we ? ~(hi ? be[2] : be[0]) : 1'b0;
    b.ub        = we ? ~(hi ? be[3] : be[1]) : 1'b0;
    return b;
  endfunction

  function automatic bus_t idle_bus(input logic [ADDR_W-1:0] adr);
    bus_t b;
    b.adr       = adr;
    b.dout      = '0;
    b.drive     = 1'b0;
    b.mem_write = 1'b0;
    b.mem_read  = 1'b0;
    b.ce        = 1'b1;
    b.ub        = 1'b1;
    b.lb        = 1'b1;
    return b;
  endfunction

  function automatic logic skip_pair(input logic we, input logic [1:0] be_pair);
    return SKIP_EN && we && (be_pair == 2'b00);
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-2:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [15:0]       lo_q, lo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ready_q, ready_d;
  bus_t              bus_q, bus_d;
  logic              beat_last;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:ADDR_W+1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    ready_d     = ready_q;
    bus_d       = bus_q;
    beat_last   = (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          idx_d   = req_addr[ADDR_W:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          ready_d = 1'b0;
          cnt_d   = '0;
          if (!skip_pair(req_we, req_be[1:0])) begin
            state_d = LO;
            bus_d   = beat_bus(1'b0, req_we, req_addr[ADDR_W:2], req_wdata, req_be);
          end else if (!skip_pair(req_we, req_be[3:2])) begin
            state_d = HI;
            bus_d   = beat_bus(1'b1, req_we, req_addr[ADDR_W:2], req_wdata, req_be);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end
      LO: begin
        if (beat_last) begin
          cnt_d = '0;
          if (!we_q) lo_d = MemData;
          if (!skip_pair(we_q, be_q[3:2])) begin
            state_d = HI;
            bus_d   = beat_bus(1'b1, we_q, idx_q, wdata_q, be_q);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            bus_d       = idle_bus(bus_q.adr);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        if (beat_last) begin
          cnt_d = '0;
          // rsp_rdata only moves when a read completes, so writes leave it untouched.
          if (!we_q) rdata_d = {MemData, lo_q};
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          bus_d       = idle_bus(bus_q.adr);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        bus_d   = idle_bus(bus_q.adr);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      lo_q        <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      bus_q       <= idle_bus('0);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      bus_q       <= bus_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign New_adr   = bus_q.adr;
  assign MemData   = bus_q.drive ? bus_q.dout : 16'hzzzz;
  assign MemWrite  = bus_q.mem_write;
  assign MemRead   = bus_q.mem_read;
  assign CE        = bus_q.ce;
  assign UB        = bus_q.ub;
  assign LB        = bus_q.lb;

endmodule

// File: tb/tb_sram_ctrl.sv
`timescale 1ns/1ps
// Bench for sram_ctrl: instance dut (WAIT_CYCLES=1) and dut2 (WAIT_CYCLES=2), each on its own SRAM model.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_BEAT_SKIP_EN
  localparam int LAT_HI_ONLY = 2;
  localparam int LAT_LO_ONLY = 2;
  localparam int LAT_NONE    = 1;
`else
  localparam int LAT_HI_ONLY = 3;
  localparam int LAT_LO_ONLY = 3;
  localparam int LAT_NONE    = 3;
`endif

  typedef struct packed {
    logic [19:0] adr;
    logic        ub;
    logic        lb;
    logic        mw;
    logic        mr;
    logic [15:0] md;
  } beat_t;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        v1, v2;
  logic        rdy1, rdy2, rv1, rv2, mw1, mw2, mr1, mr2, ce1, ce2, ub1, ub2, lb1, lb2;
  logic [31:0] rd1, rd2;
  logic [19:0] adr1, adr2;
  wire  [15:0] md1, md2;

  assign v1 = req_valid && !sel;
  assign v2 = req_valid && sel;

  sram_ctrl #(.WAIT_CYCLES(1), .ADDR_W(20)) dut (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv1),
    .rsp_rdata(rd1), .New_adr(adr1), .MemData(md1), .MemWrite(mw1), .MemRead(mr1),
    .CE(ce1), .UB(ub1), .LB(lb1));

  sram_ctrl #(.WAIT_CYCLES(2), .ADDR_W(20)) dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv2),
    .rsp_rdata(rd2), .New_adr(adr2), .MemData(md2), .MemWrite(mw2), .MemRead(mr2),
    .CE(ce2), .UB(ub2), .LB(lb2));

  // Pull-ups make a released bus read as 16'hFFFF.
  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup (md1[i]);
    pullup (md2[i]);
  end

  logic [15:0] mem1 [0:1023];
  logic [15:0] mem2 [0:1023];

  assign md1 = (!ce1 && mr1) ? mem1[adr1[9:0]] : 16'hzzzz;
  assign md2 = (!ce2 && mr2) ? mem2[adr2[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce1 && mw1) begin
      if (!lb1) mem1[adr1[9:0]][7:0]  <= md1[7:0];
      if (!ub1) mem1[adr1[9:0]][15:8] <= md1[15:8];
    end
    if (!ce2 && mw2) begin
      if (!lb2) mem2[adr2[9:0]][7:0]  <= md2[7:0];
      if (!ub2) mem2[adr2[9:0]][15:8] <= md2[15:8];
    end
  end

  logic        m_rdy, m_rv, m_ce, m_ub, m_lb, m_mw, m_mr;
  logic [31:0] m_rd;
  logic [19:0] m_adr;
  logic [15:0] m_md;
  assign m_rdy = sel ? rdy2 : rdy1;
  assign m_rv  = sel ? rv2  : rv1;
  assign m_rd  = sel ? rd2  : rd1;
  assign m_ce  = sel ? ce2  : ce1;
  assign m_ub  = sel ? ub2  : ub1;
  assign m_lb  = sel ? lb2  : lb1;
  assign m_mw  = sel ? mw2  : mw1;
  assign m_mr  = sel ? mr2  : mr1;
  assign m_adr = sel ? adr2 : adr1;
  assign m_md  = sel ? md2  : md1;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  beat_t blog[$];
  exp_t  exp_q[$];
  int    acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!m_ce) blog.push_back({m_adr, m_ub, m_lb, m_mw, m_mr, m_md});
  end

  function automatic beat_t bt(input logic [19:0] adr, input logic ub, input logic lb,
                               input logic mw, input logic mr, input logic [15:0] md);
    return {adr, ub, lb, mw, mr, md};
  endfunction

  // Drives one request, holding req_valid until accepted, and queues its expected response.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input int exp_lat);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!m_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!m_rdy) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", m_rdy, n);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      e.is_read = !we;
      e.rdata   = exp_rdata;
      e.lat     = exp_lat;
      e.acc     = cyc;
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      req_valid = 1'b0;
    end
  endtask

  task automatic collect(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!m_rv && t < 100);
      checks++;
      if (!m_rv) begin
        errors++;
        $display("FAIL %s_rsp_timeout: no rsp_valid in %0d cycles, required one", name, t);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_unexpected_rsp: rsp_valid=1 with nothing outstanding, required 0", name);
      end else begin
        e = exp_q.pop_front();
        if (cyc - e.acc + 1 !== e.lat) begin
          errors++;
          $display("FAIL %s_latency: %0d cycles, required %0d", name, cyc - e.acc + 1, e.lat);
        end
        if (e.is_read) begin
          checks++;
          if (m_rd !== e.rdata) begin
            errors++;
            $display("FAIL %s_rdata: rsp_rdata=%h, required %h", name, m_rd, e.rdata);
          end
        end
        @(negedge clk);
        checks++;
        if (m_rv !== 1'b0) begin
          errors++;
          $display("FAIL %s_rsp_pulse: rsp_valid=%0b one cycle later, required 0", name, m_rv);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdy1, rv1, rd1} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_rsp1: ready/valid/rdata=%b/%b/%h, required 1/0/00000000", rdy1, rv1, rd1);
    end
    checks++;
    if ({adr1, mr1, mw1, ce1, ub1, lb1, md1} !== {20'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset_bus1: adr=%h mr=%b mw=%b ce=%b ub=%b lb=%b md=%h, required 00000 0 0 1 1 1 ffff",
               adr1, mr1, mw1, ce1, ub1, lb1, md1);
    end
    checks++;
    if ({rdy2, rv2, rd2, adr2, mr2, mw2, ce2, ub2, lb2, md2} !==
        {1'b1, 1'b0, 32'h0, 20'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset_dut2: rdy=%b rv=%b rd=%h adr=%h ce=%b md=%h, required 1 0 0 0 1 ffff",
               rdy2, rv2, rd2, adr2, ce2, md2);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ce1, mw1, md1} !== {1'b0, 1'b1, 16'h5678}) begin
      errors++;
      $display("FAIL midrst_lo_beat: ce=%b mw=%b md=%h, required 0 1 5678", ce1, mw1, md1);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({ce1, mw1, md1, rdy1} !== {1'b1, 1'b0, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL midrst_release: ce=%b mw=%b md=%h ready=%b, required 1 0 ffff 1", ce1, mw1, md1, rdy1);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rv1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL midrst_no_rsp: %0d rsp_valid cycles, required 0", n);
    end
  endtask

  task automatic test_write_read();
    beat_t eb[$];
    sel = 1'b0;
    blog.delete();
    issue(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 32'h0, 3);
    collect(1, "wr_full");
    eb.push_back(bt(20'h4, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF));
    eb.push_back(bt(20'h5, 1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD));
    checks++;
    if (blog.size() != eb.size()) begin
      errors++;
      $display("FAIL wr_full_beats: %0d beat cycles, required %0d", blog.size(), eb.size());
    end else begin
      foreach (eb[i]) begin
        checks++;
        if (blog[i] !== eb[i]) begin
          errors++;
          $display("FAIL wr_full_beat%0d: got %h, required %h", i, blog[i], eb[i]);
        end
      end
    end
    checks++;
    if ({mem1[5], mem1[4]} !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_full_mem: hw5/hw4=%h/%h, required dead/beef", mem1[5], mem1[4]);
    end
    issue(1'b0, 32'h8, 32'h0, 4'h0, 32'hDEAD_BEEF, 3);
    collect(1, "rd_full");
  endtask

  task automatic test_partial_write();
    beat_t eb[$];
    sel = 1'b0;
    blog.delete();
    issue(1'b1, 32'h8, 32'h1122_3344, 4'b0100, 32'h0, LAT_HI_ONLY);
    collect(1, "wr_part");
`ifndef SRAM_CTRL_BEAT_SKIP_EN
    eb.push_back(bt(20'h4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h3344));
`endif
    eb.push_back(bt(20'h5, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1122));
    checks++;
    if (blog.size() != eb.size()) begin
      errors++;
      $display("FAIL wr_part_beats: %0d beat cycles, required %0d", blog.size(), eb.size());
    end else begin
      foreach (eb[i]) begin
        checks++;
        if (blog[i] !== eb[i]) begin
          errors++;
          $display("FAIL wr_part_beat%0d: got %h, required %h", i, blog[i], eb[i]);
        end
      end
    end
    issue(1'b0, 32'h8, 32'h0, 4'h0, 32'hDE22_BEEF, 3);
    collect(1, "rd_part");
  endtask

  task automatic test_beat_skip();
    beat_t eb[$];
    sel = 1'b0;
    issue(1'b1, 32'h10, 32'h6666_4444, 4'hF, 32'h0, 3);
    collect(1, "skip_pre");
    blog.delete();
    issue(1'b1, 32'h10, 32'hAAAA_5555, 4'b0011, 32'h0, LAT_LO_ONLY);
    collect(1, "skip_lo_only");
    eb.push_back(bt(20'h8, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555));
`ifndef SRAM_CTRL_BEAT_SKIP_EN
    eb.push_back(bt(20'h9, 1'b1, 1'b1, 1'b1, 1'b0, 16'hAAAA));
`endif
    issue(1'b1, 32'h10, 32'h0F0F_0F0F, 4'b0000, 32'h0, LAT_NONE);
    collect(1, "skip_none");
`ifndef SRAM_CTRL_BEAT_SKIP_EN
    eb.push_back(bt(20'h8, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0F0F));
    eb.push_back(bt(20'h9, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0F0F));
`endif
    checks++;
    if (blog.size() != eb.size()) begin
      errors++;
      $display("FAIL skip_beats: %0d beat cycles, required %0d", blog.size(), eb.size());
    end else begin
      foreach (eb[i]) begin
        checks++;
        if (blog[i] !== eb[i]) begin
          errors++;
          $display("FAIL skip_beat%0d: got %h, required %h", i, blog[i], eb[i]);
        end
      end
    end
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h6666_5555, 3);
    collect(1, "skip_rd");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    acc_q.delete();
    fork
      begin
        issue(1'b0, 32'h8, 32'h0, 4'h0, 32'hDE22_BEEF, 3);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h6666_5555, 3);
      end
      collect(2, "b2b");
    join
    checks++;
    if (acc_q.size() != 2 || acc_q[1] - acc_q[0] != 4) begin
      errors++;
      $display("FAIL b2b_spacing: %0d accepts, spacing %0d, required 2 accepts 4 cycles apart",
               acc_q.size(), (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1);
    end
  endtask

  task automatic test_stall_wrap();
    beat_t eb[$];
    sel = 1'b1;
    blog.delete();
    issue(1'b1, 32'h001F_FFFC, 32'hCAFE_F00D, 4'hF, 32'h0, 5);
    collect(1, "wrap_wr");
    checks++;
    if ({mem2[10'h3FF], mem2[10'h3FE]} !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL wrap_mem: hw fffff/ffffe=%h/%h, required cafe/f00d", mem2[10'h3FF], mem2[10'h3FE]);
    end
    blog.delete();
    acc_q.delete();
    fork
      begin
        issue(1'b0, 32'h001F_FFFC, 32'h0, 4'h0, 32'hCAFE_F00D, 5);
        issue(1'b0, 32'h001F_FFFC, 32'h0, 4'h0, 32'hCAFE_F00D, 5);
      end
      collect(2, "wrap_rd");
    join
    checks++;
    if (acc_q.size() != 2 || acc_q[1] - acc_q[0] != 6) begin
      errors++;
      $display("FAIL stall_spacing: %0d accepts, spacing %0d, required 2 accepts 6 cycles apart",
               acc_q.size(), (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1);
    end
    for (int r = 0; r < 2; r++) begin
      eb.push_back(bt(20'hFFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 16'hF00D));
      eb.push_back(bt(20'hFFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 16'hF00D));
      eb.push_back(bt(20'hFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hCAFE));
      eb.push_back(bt(20'hFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hCAFE));
    end
    checks++;
    if (blog.size() != eb.size()) begin
      errors++;
      $display("FAIL wrap_beats: %0d beat cycles, required %0d", blog.size(), eb.size());
    end else begin
      foreach (eb[i]) begin
        checks++;
        if (blog[i] !== eb[i]) begin
          errors++;
          $display("FAIL wrap_beat%0d: got %h, required %h", i, blog[i], eb[i]);
        end
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_write_read();
    test_partial_write();
    test_beat_skip();
    test_back_to_back();
    test_stall_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
